mult_share_arbiter: RTL and testbench

//  Shares one combinational WIDTHxWIDTH partial-product array multiplier between two

---
 rtl/mult_share_arbiter.sv | 124 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// mult_share_arbiter : two-requester round-robin share of one array multiplier
// Rev 1.0
// ============================================================================
module mult_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 req1_ready,
  output logic                 res_valid,
  output logic [2*WIDTH-1:0]   res_p,
  output logic                 res_id,
  input  logic                 res_ready,
  output logic                 busy,
  output logic [CNT_W-1:0]     ops_cnt
);

  localparam int               c_PW      = 2 * WIDTH;
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_lat;
  logic [WIDTH-1:0] r_b_lat;
  logic             r_id_lat;
  logic             r_last_grant;

  logic             w_idle;
  logic             w_grant;
  logic             w_hs;
  logic [c_PW-1:0]  w_prod;
  logic [c_PW-1:0]  w_pp  [WIDTH];
  logic [c_PW-1:0]  w_acc [WIDTH+1];

  // Row i of the array is the multiplicand shifted by i, gated by multiplier bit i.
  assign w_acc[0] = '0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    assign w_pp[i]    = r_b_lat[i] ? ({{WIDTH{1'b0}}, r_a_lat} << i) : '0;
    assign w_acc[i+1] = w_acc[i] + w_pp[i];
  end
  assign w_prod = w_acc[WIDTH];

  assign w_idle = (r_state == ST_IDLE);

  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign req0_ready = w_idle & req0_valid & ~w_grant;
  assign req1_ready = w_idle & req1_valid &  w_grant;
  assign w_hs       = req0_ready | req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_a_lat      <= '0;
      r_b_lat      <= '0;
      r_id_lat     <= 1'b0;
      r_last_grant <= 1'b1;
      res_valid    <= 1'b0;
      res_p        <= '0;
      res_id       <= 1'b0;
      busy         <= 1'b0;
      ops_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_a_lat      <= w_grant ? req1_a : req0_a;
            r_b_lat      <= w_grant ? req1_b : req0_b;
            r_id_lat     <= w_grant;
            r_last_grant <= w_grant;
            busy         <= 1'b1;
            r_state      <= ST_CALC;
          end
        end
        ST_CALC: begin
          res_p     <= w_prod;
          res_id    <= r_id_lat;
          res_valid <= 1'b1;
          r_state   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            if (ops_cnt != c_CNT_MAX) begin
              ops_cnt <= ops_cnt + c_CNT_ONE;
            end
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mult_share_arbiter : directed bench with a transaction-level reference model
// Rev 1.0
// ============================================================================
module tb_mult_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b1;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;

  logic        req0_ready, req1_ready, res_valid, res_id, busy;
  logic [7:0]  res_p;
  logic [15:0] ops_cnt;
  logic        s_r0, s_r1, s_rv, s_id, s_busy;
  logic [7:0]  s_p;
  logic [3:0]  ops_cnt4;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_share_arbiter #(.WIDTH(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_p(res_p), .res_id(res_id), .res_ready(res_ready),
    .busy(busy), .ops_cnt(ops_cnt)
  );

  // Narrow-counter build sharing the same stimulus, to exercise saturation.
  mult_share_arbiter #(.WIDTH(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(s_r0),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(s_r1),
    .res_valid(s_rv), .res_p(s_p), .res_id(s_id), .res_ready(res_ready),
    .busy(s_busy), .ops_cnt(ops_cnt4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one operation in flight at a time; result visible once computed.
  bit         m_inflight, m_hold, m_last, m_id, m_rid;
  int         m_ops;
  logic [7:0] m_prod, m_p;

  function automatic bit m_grant();
    return (req0_valid && req1_valid) ? !m_last : bit'(req1_valid);
  endfunction

  function automatic logic [7:0] mul(input logic [3:0] a, input logic [3:0] b);
    return 8'(int'(a) * int'(b));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inflight <= 0; m_hold <= 0; m_last <= 1; m_id <= 0; m_rid <= 0;
      m_ops <= 0; m_prod <= '0; m_p <= '0;
    end else if (!m_inflight) begin
      if (req0_valid || req1_valid) begin
        m_inflight <= 1;
        m_last     <= m_grant();
        m_id       <= m_grant();
        m_prod     <= m_grant() ? mul(req1_a, req1_b) : mul(req0_a, req0_b);
      end
    end else if (!m_hold) begin
      m_hold <= 1;
      m_p    <= m_prod;
      m_rid  <= m_id;
    end else if (res_ready) begin
      m_inflight <= 0;
      m_hold     <= 0;
      m_ops      <= m_ops + 1;
    end
  end

  always @(negedge clk) begin
    check("req0_ready", req0_ready, !m_inflight && req0_valid && !m_grant());
    check("req1_ready", req1_ready, !m_inflight && req1_valid &&  m_grant());
    check("res_valid",  res_valid,  m_hold);
    check("busy",       busy,       m_inflight);
    check("res_p",      res_p,      m_p);
    check("res_id",     res_id,     m_rid);
    check("ops_cnt",    ops_cnt,    (m_ops > 65535) ? 65535 : m_ops);
    check("ops_cnt4",   ops_cnt4,   (m_ops > 15) ? 15 : m_ops);
    check("res_valid4", s_rv,       m_hold);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Presents one request and returns after the handshake edge with valid dropped.
  task automatic do_op(input bit id, input logic [3:0] a, input logic [3:0] b, output int hs);
    bit done = 0;
    hs = -1;
    if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        hs   = cyc;
        done = 1;
      end
      tick();
    end
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    if (!done) check("op_timeout", 0, 1);
  endtask

  task automatic wait_result(input logic [7:0] ep, input bit eid, output int vc);
    bit got = 0;
    vc = -1;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (res_valid === 1'b1) begin
        got = 1;
        vc  = cyc;
        check("lit_res_p", res_p, ep);
        check("lit_res_id", res_id, eid);
      end
      tick();
    end
    if (!got) check("res_timeout", 0, 1);
  endtask

  initial begin
    int  hs, vc, nhs;
    bit  exp_g, g;
    logic [3:0] a, b;

    #1;
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ops_cnt", ops_cnt, 0);
    check("rst_res_p", res_p, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single request from requester 0.
    do_op(0, 4'd3, 4'd5, hs);
    wait_result(8'd15, 0, vc);
    check("t1_latency", vc - hs, 2);
    check("t1_ops_cnt", ops_cnt, 1);

    // Contention from reset: requester 0 wins first, then alternation.
    do_reset();
    req0_a = 4'd7;  req0_b = 4'd9;  req1_a = 4'd15; req1_b = 4'd15;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("t2_first_r0", req0_ready, 1);
    check("t2_first_r1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    wait_result(8'd63, 0, vc);
    #1;
    check("t2_then_r1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    wait_result(8'd225, 1, vc);
    req0_valid = 1'b1; req1_valid = 1'b1;
    exp_g = 0; nhs = 0;
    for (int n = 0; n < 80 && nhs < 8; n++) begin
      #1;
      if (req0_ready || req1_ready) begin
        g = req1_ready;
        check("t2_alternate", g, exp_g);
        exp_g = !exp_g;
        nhs++;
        tick();
        if (g) begin req1_a = 4'(nhs * 3); req1_b = 4'(nhs + 5); end
        else   begin req0_a = 4'(nhs * 7); req0_b = 4'(15 - nhs); end
      end else begin
        tick();
      end
    end
    check("t2_alt_count", nhs, 8);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();

    // Back-pressure: result held while the consumer stalls.
    res_ready = 1'b0;
    do_op(0, 4'd11, 4'd13, hs);
    wait_result(8'd143, 0, vc);
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (5) begin
      #1;
      check("t3_r0", req0_ready, 0);
      check("t3_r1", req1_ready, 0);
      check("t3_valid", res_valid, 1);
      check("t3_res_p", res_p, 143);
      check("t3_ops_cnt", ops_cnt, 10);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    tick();
    #1;
    check("t3_accepted", res_valid, 0);
    check("t3_idle", busy, 0);
    check("t3_ops_after", ops_cnt, 11);
    tick();

    // Asynchronous reset while the product is being computed.
    do_op(1, 4'd6, 4'd6, hs);
    #1;
    rst_n = 1'b0;
    #1;
    check("t4_res_valid", res_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_ops_cnt", ops_cnt, 0);
    check("t4_res_p", res_p, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_op(1, 4'd4, 4'd4, hs);
    wait_result(8'd16, 1, vc);
    check("t4_ops_cnt_after", ops_cnt, 1);

    // Every operand pair, alternating requesters; also drives the 4-bit counter to saturation.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      a = 4'(i >> 4);
      b = 4'(i);
      do_op(bit'(i % 2), a, b, hs);
      wait_result(mul(a, b), bit'(i % 2), vc);
      if (i == 14) begin
        check("t6_cnt4_at15", ops_cnt4, 15);
        check("t6_cnt_at15", ops_cnt, 15);
      end
      if (i == 19) begin
        check("t6_cnt4_at20", ops_cnt4, 15);
        check("t6_cnt_at20", ops_cnt, 20);
      end
    end
    check("t5_ops_cnt", ops_cnt, 256);
    check("t6_cnt4_final", ops_cnt4, 15);
    check("t5_max_lit", mul(4'hF, 4'hF), 225);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
